// File: rtl/channel_scanner_pkg.sv
// Shared definitions for the channel scanner: FSM encoding and the
// circular "next set mask bit" search used to step through channels.
package channel_scanner_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  localparam int MAX_CH   = 32;
  localparam int CH_IDX_W = $clog2(MAX_CH);

  // Returns the first set bit strictly after cur, wrapping modulo n.
  // Calling with cur = n-1 yields the lowest set bit. Returns 0 for an empty mask.
  function automatic int next_set_bit(input logic [MAX_CH-1:0] mask,
                                      input int                cur,
                                      input int                n);
    int   res;
    int   idx;
    logic found;
    res   = 0;
    found = 1'b0;
    for (int i = 1; i <= MAX_CH; i++) begin
      idx = (cur + i) % n;
      if (i <= n && !found && mask[idx[CH_IDX_W-1:0]]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/channel_scanner_scan_tag_delay.sv
// Fixed-latency delay line carrying {valid, sel} so the flag and the channel
// tag line up with the output of the downstream registered mux.
module scan_tag_delay #(
  parameter int SEL_WIDTH = 2,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 valid_i,
  input  logic [SEL_WIDTH-1:0] sel_i,
  output logic                 valid_o,
  output logic [SEL_WIDTH-1:0] tag_sel_o
);

  generate
    if (LATENCY == 0) begin : g_bypass
      assign valid_o   = valid_i;
      assign tag_sel_o = sel_i;
    end else begin : g_pipe
      logic [SEL_WIDTH:0] pipe_q [LATENCY];

      always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
          for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= {valid_i, sel_i};
          for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign {valid_o, tag_sel_o} = pipe_q[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/channel_scanner.sv
// Round-robin scanner over the set bits of a channel mask: dwells a fixed
// number of cycles per channel, flags settled samples, and marks frame ends.
module channel_scanner
  import channel_scanner_pkg::*;
#(
  parameter int N_INPUTS  = 3,
  parameter int SEL_WIDTH = 2,
  parameter int CNT_WIDTH = 16,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 enable,
  input  logic                 single_shot,
  input  logic [N_INPUTS-1:0]  mask,
  input  logic [CNT_WIDTH-1:0] dwell,
  input  logic [CNT_WIDTH-1:0] settle,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 valid,
  output logic [SEL_WIDTH-1:0] tag_sel,
  output logic                 frame_done,
  output logic                 busy
);

  // Reset asserts asynchronously but releases on a clock edge, so the
  // first possible IDLE->SCAN transition is the second edge after release.
  logic rst_n_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) rst_n_q <= 1'b0;
    else          rst_n_q <= 1'b1;
  end

  scan_state_e            state_q, state_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [N_INPUTS-1:0]    mask_q, mask_d;
  logic [CNT_WIDTH-1:0]   dwell_q, dwell_d;
  logic [CNT_WIDTH-1:0]   settle_q, settle_d;
  logic                   single_shot_q, single_shot_d;

  logic [CNT_WIDTH-1:0]   dwell_eff;
  logic                   last_cnt;
  logic                   wrap;
  logic                   frame_end;
  logic                   pre_valid;
  int                     nxt_idx;
  int                     first_idx;

  // A dwell of 0 behaves as 1; dwell_eff >= 1 keeps the terminal compare wrap-free.
  assign dwell_eff = (dwell_q == '0) ? CNT_WIDTH'(1) : dwell_q;
  assign last_cnt  = (cnt_q == dwell_eff - CNT_WIDTH'(1));
  assign nxt_idx   = next_set_bit(MAX_CH'(mask_q), int'(sel_q), N_INPUTS);
  assign first_idx = next_set_bit(MAX_CH'(mask), N_INPUTS - 1, N_INPUTS);
  // The search wrapping back (or staying put) means sel is the highest set channel.
  assign wrap      = (nxt_idx <= int'(sel_q));
  assign frame_end = (state_q == SCAN) && last_cnt && wrap;
  assign pre_valid = (state_q == SCAN) && (cnt_q >= settle_q);

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    mask_d        = mask_q;
    dwell_d       = dwell_q;
    settle_d      = settle_q;
    single_shot_d = single_shot_q;
    case (state_q)
      IDLE: begin
        if (enable && (mask != '0)) begin
          state_d       = SCAN;
          mask_d        = mask;
          dwell_d       = dwell;
          settle_d      = settle;
          single_shot_d = single_shot;
          sel_d         = SEL_WIDTH'(first_idx);
          cnt_d         = '0;
        end
      end
      SCAN: begin
        if (!last_cnt) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end else begin
          cnt_d = '0;
          if (!wrap) begin
            sel_d = SEL_WIDTH'(nxt_idx);
          end else if (single_shot_q || !enable || (mask == '0)) begin
            state_d = IDLE;
          end else begin
            mask_d        = mask;
            dwell_d       = dwell;
            settle_d      = settle;
            single_shot_d = single_shot;
            sel_d         = SEL_WIDTH'(first_idx);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      cnt_q         <= '0;
      mask_q        <= '0;
      dwell_q       <= '0;
      settle_q      <= '0;
      single_shot_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      dwell_q       <= dwell_d;
      settle_q      <= settle_d;
      single_shot_q <= single_shot_d;
    end
  end

  assign sel        = sel_q;
  assign busy       = (state_q == SCAN);
  assign frame_done = frame_end;

  scan_tag_delay #(
    .SEL_WIDTH (SEL_WIDTH),
    .LATENCY   (LATENCY)
  ) u_tag_delay (
    .clk       (clk),
    .aresetn   (rst_n_q),
    .valid_i   (pre_valid),
    .sel_i     (sel_q),
    .valid_o   (valid),
    .tag_sel_o (tag_sel)
  );

endmodule

// File: tb/tb_channel_scanner.sv
// Directed bench for channel_scanner: each task runs one scenario and
// checks sel / frame_done / valid / tag_sel / busy against hand-derived values.
module tb_channel_scanner;

  logic        clk;
  logic        aresetn;
  logic        enable;
  logic        single_shot;
  logic [2:0]  mask;
  logic [15:0] dwell;
  logic [15:0] settle;
  logic [1:0]  sel;
  logic        valid;
  logic [1:0]  tag_sel;
  logic        frame_done;
  logic        busy;

  int checks;
  int errors;

  channel_scanner #(
    .N_INPUTS  (3),
    .SEL_WIDTH (2),
    .CNT_WIDTH (16),
    .LATENCY   (2)
  ) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .enable      (enable),
    .single_shot (single_shot),
    .mask        (mask),
    .dwell       (dwell),
    .settle      (settle),
    .sel         (sel),
    .valid       (valid),
    .tag_sel     (tag_sel),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Resets, loads inputs, then raises enable so SCAN is entered on the
  // next edge; returns sampled just after that entry edge (cycle k = 0).
  task automatic start_run(input logic [2:0] m, input logic [15:0] d,
                           input logic [15:0] s, input logic ss);
    aresetn     = 1'b0;
    enable      = 1'b0;
    mask        = m;
    dwell       = d;
    settle      = s;
    single_shot = ss;
    step();
    step();
    aresetn = 1'b1;
    step();
    enable = 1'b1;
    step();
  endtask

  task automatic test_reset();
    aresetn     = 1'b0;
    enable      = 1'b1;
    single_shot = 1'b0;
    mask        = 3'b111;
    dwell       = 16'd4;
    settle      = 16'd0;
    step();
    checks++; if (sel !== 2'd0)      begin errors++; $display("FAIL reset_sel: got %0d want 0", sel); end
    checks++; if (tag_sel !== 2'd0)  begin errors++; $display("FAIL reset_tag: got %0d want 0", tag_sel); end
    checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    aresetn = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_edge1_busy: got %b want 0", busy); end
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL release_edge2_busy: got %b want 1", busy); end
    checks++; if (sel !== 2'd0)  begin errors++; $display("FAIL release_edge2_sel: got %0d want 0", sel); end
  endtask

  // mask 111, dwell 4, settle 1; enable dropped mid second frame.
  task automatic test_continuous();
    logic [1:0] e_sel, e_tag;
    logic       e_fd, e_v;
    start_run(3'b111, 16'd4, 16'd1, 1'b0);
    for (int k = 0; k < 24; k++) begin
      e_sel = 2'((k / 4) % 3);
      e_fd  = (k % 12 == 11);
      e_v   = (k >= 2) && (((k - 2) % 4) >= 1);
      e_tag = (k >= 2) ? 2'(((k - 2) / 4) % 3) : 2'd0;
      checks++; if (sel !== e_sel)     begin errors++; $display("FAIL cont_sel k=%0d: got %0d want %0d", k, sel, e_sel); end
      checks++; if (frame_done !== e_fd) begin errors++; $display("FAIL cont_fd k=%0d: got %b want %b", k, frame_done, e_fd); end
      checks++; if (valid !== e_v)     begin errors++; $display("FAIL cont_valid k=%0d: got %b want %b", k, valid, e_v); end
      checks++; if (tag_sel !== e_tag) begin errors++; $display("FAIL cont_tag k=%0d: got %0d want %0d", k, tag_sel, e_tag); end
      checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL cont_busy k=%0d: got %b want 1", k, busy); end
      if (k == 13) enable = 1'b0;
      step();
    end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL cont_idle_busy: got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL cont_idle_fd: got %b want 0", frame_done); end
    checks++; if (sel !== 2'd2)        begin errors++; $display("FAIL cont_idle_sel_hold: got %0d want 2", sel); end
  endtask

  // mask 101, dwell 0 behaves as 1: sel alternates every cycle.
  task automatic test_fast_dwell();
    logic [1:0] e_sel, e_tag;
    logic       e_fd, e_v;
    start_run(3'b101, 16'd0, 16'd0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      e_sel = (k % 2 == 1) ? 2'd2 : 2'd0;
      e_fd  = (k % 2 == 1);
      e_v   = (k >= 2);
      e_tag = (k >= 2) ? e_sel : 2'd0;
      checks++; if (sel !== e_sel)     begin errors++; $display("FAIL fast_sel k=%0d: got %0d want %0d", k, sel, e_sel); end
      checks++; if (frame_done !== e_fd) begin errors++; $display("FAIL fast_fd k=%0d: got %b want %b", k, frame_done, e_fd); end
      checks++; if (valid !== e_v)     begin errors++; $display("FAIL fast_valid k=%0d: got %b want %b", k, valid, e_v); end
      checks++; if (tag_sel !== e_tag) begin errors++; $display("FAIL fast_tag k=%0d: got %0d want %0d", k, tag_sel, e_tag); end
      step();
    end
  endtask

  // single_shot, mask 110, dwell 3: one frame then IDLE, valid drains.
  task automatic test_single_shot();
    logic [1:0] e_sel, e_tag;
    logic       e_fd, e_v, e_busy;
    start_run(3'b110, 16'd3, 16'd0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      e_sel  = (k < 3) ? 2'd1 : 2'd2;
      e_fd   = (k == 5);
      e_busy = (k <= 5);
      e_v    = (k >= 2) && (k <= 7);
      e_tag  = (k < 2) ? 2'd0 : ((k < 5) ? 2'd1 : 2'd2);
      checks++; if (sel !== e_sel)     begin errors++; $display("FAIL ss_sel k=%0d: got %0d want %0d", k, sel, e_sel); end
      checks++; if (frame_done !== e_fd) begin errors++; $display("FAIL ss_fd k=%0d: got %b want %b", k, frame_done, e_fd); end
      checks++; if (busy !== e_busy)   begin errors++; $display("FAIL ss_busy k=%0d: got %b want %b", k, busy, e_busy); end
      checks++; if (valid !== e_v)     begin errors++; $display("FAIL ss_valid k=%0d: got %b want %b", k, valid, e_v); end
      checks++; if (tag_sel !== e_tag) begin errors++; $display("FAIL ss_tag k=%0d: got %0d want %0d", k, tag_sel, e_tag); end
      if (k == 0) enable = 1'b0;
      step();
    end
  endtask

  // mask 111 -> 001 mid-frame: change takes effect at the frame boundary.
  task automatic test_mask_change();
    logic [1:0] e_sel;
    logic       e_fd;
    start_run(3'b111, 16'd2, 16'd0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      e_sel = (k < 6) ? 2'(k / 2) : 2'd0;
      e_fd  = (k == 5) || (k >= 7 && k % 2 == 1);
      checks++; if (sel !== e_sel)       begin errors++; $display("FAIL mchg_sel k=%0d: got %0d want %0d", k, sel, e_sel); end
      checks++; if (frame_done !== e_fd) begin errors++; $display("FAIL mchg_fd k=%0d: got %b want %b", k, frame_done, e_fd); end
      if (k == 0) mask = 3'b001;
      step();
    end
  endtask

  // Reset pulsed in the middle of a dwell on channel 2, then restart.
  task automatic test_reset_mid();
    logic [1:0] e_sel;
    start_run(3'b110, 16'd4, 16'd0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      e_sel = (k < 4) ? 2'd1 : 2'd2;
      checks++; if (sel !== e_sel) begin errors++; $display("FAIL rmid_sel k=%0d: got %0d want %0d", k, sel, e_sel); end
      if (k < 5) step();
    end
    aresetn = 1'b0;
    #2;
    checks++; if (sel !== 2'd0)        begin errors++; $display("FAIL rmid_async_sel: got %0d want 0", sel); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rmid_async_busy: got %b want 0", busy); end
    checks++; if (valid !== 1'b0)      begin errors++; $display("FAIL rmid_async_valid: got %b want 0", valid); end
    checks++; if (tag_sel !== 2'd0)    begin errors++; $display("FAIL rmid_async_tag: got %0d want 0", tag_sel); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rmid_async_fd: got %b want 0", frame_done); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rmid_hold_fd k=%0d: got %b want 0", k, frame_done); end
    end
    aresetn = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_restart_edge1_busy: got %b want 0", busy); end
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_restart_busy: got %b want 1", busy); end
    checks++; if (sel !== 2'd1)  begin errors++; $display("FAIL rmid_restart_sel: got %0d want 1", sel); end
  endtask

  // settle == dwell: sel still cycles and frames end, but nothing is valid.
  task automatic test_settle_all();
    logic [1:0] e_sel;
    logic       e_fd;
    start_run(3'b011, 16'd5, 16'd5, 1'b0);
    for (int k = 0; k < 20; k++) begin
      e_sel = 2'((k / 5) % 2);
      e_fd  = (k % 10 == 9);
      checks++; if (sel !== e_sel)       begin errors++; $display("FAIL settle_sel k=%0d: got %0d want %0d", k, sel, e_sel); end
      checks++; if (frame_done !== e_fd) begin errors++; $display("FAIL settle_fd k=%0d: got %b want %b", k, frame_done, e_fd); end
      checks++; if (valid !== 1'b0)      begin errors++; $display("FAIL settle_valid k=%0d: got %b want 0", k, valid); end
      step();
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    aresetn     = 1'b0;
    enable      = 1'b0;
    single_shot = 1'b0;
    mask        = '0;
    dwell       = '0;
    settle      = '0;
    #3;
    test_reset();
    test_continuous();
    test_fast_dwell();
    test_single_shot();
    test_mask_change();
    test_reset_mid();
    test_settle_all();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
